// File: rtl/game_io_conditioner.sv
// Board I/O front-end for a game core: clock-enable divider, key conditioning
// (sync, debounce, enable-aligned press/release events) and registered video.
module game_io_conditioner #(
    parameter int DIV            = 2,
    parameter int N_KEYS         = 4,
    parameter int DEB_CYCLES     = 4,
    parameter bit KEY_ACTIVE_LOW = 1'b0,
    parameter int RGB_W          = 3,
    parameter bit SYNC_IDLE      = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_raw,
    output logic              game_ce,
    output logic [N_KEYS-1:0] keys_lvl,
    output logic [N_KEYS-1:0] keys_press,
    output logic [N_KEYS-1:0] keys_rel,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [RGB_W-1:0]  rgb_in,
    output logic              hsync,
    output logic              vsync,
    output logic [RGB_W-1:0]  rgb
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [DW-1:0] div_cnt;
    logic          ce_next;

    assign ce_next = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            game_ce <= 1'b0;
        end else begin
            game_ce <= ce_next;
            div_cnt <= ce_next ? '0 : div_cnt + 1'b1;
        end
    end

    logic [N_KEYS-1:0] sync1, sync2, stable, stable_next;
    logic [N_KEYS-1:0] pend_p, pend_r;
    logic [N_KEYS-1:0] accept, rise_now, fall_now;
    logic [CW-1:0]     cnt [N_KEYS];

    always_comb begin
        accept = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            accept[k] = (sync2[k] != stable[k]) && (cnt[k] == DEB_LAST);
        end
    end

    assign rise_now    = accept & sync2;
    assign fall_now    = accept & ~sync2;
    assign stable_next = stable ^ accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1  <= keys_raw ^ {N_KEYS{KEY_ACTIVE_LOW}};
            sync2  <= sync1;
            stable <= stable_next;
            // Any agreeing sample restarts the run, so short glitches are dropped
            for (int k = 0; k < N_KEYS; k++) begin
                if (sync2[k] == stable[k] || accept[k]) begin
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_p     <= '0;
            pend_r     <= '0;
            keys_lvl   <= '0;
            keys_press <= '0;
            keys_rel   <= '0;
        end else if (ce_next) begin
            keys_press <= pend_p | rise_now;
            keys_rel   <= pend_r | fall_now;
            keys_lvl   <= stable_next;
            pend_p     <= '0;
            pend_r     <= '0;
        end else begin
            keys_press <= '0;
            keys_rel   <= '0;
            pend_p     <= pend_p | rise_now;
            pend_r     <= pend_r | fall_now;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= SYNC_IDLE;
            vsync <= SYNC_IDLE;
            rgb   <= '0;
        end else begin
            hsync <= hsync_in;
            vsync <= vsync_in;
            rgb   <= rgb_in;
        end
    end

endmodule
